watch_core_multi_alarm: RTL and testbench

- Parametrised successor to the single-alarm watch core: 24-hour timekeeping with an internal 1 Hz prescaler, NUM_ALARMS independently enabled daily alarms with timed ringing, and a free-running stopwatch with lap capture.
- Driven by three single-cycle button pulses from the existing pulse generators; sits between the button front end and the display driver.

---
 rtl/watch_core_multi_alarm.sv | 220 ++++++++++++++++++++++
 tb/tb_watch_core_multi_alarm.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_core_multi_alarm.sv
// watch_core_multi_alarm: 24-hour clock with 1 Hz prescaler, NUM_ALARMS
// daily alarm slots with timed ringing, and a lap-capable stopwatch.
module watch_core_multi_alarm #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int NUM_ALARMS    = 4,
    parameter int RING_SECS     = 30,
    parameter int AW            = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_p,
    input  logic                  toggle_p,
    input  logic                  confirm_p,
    input  logic                  stop_ring_p,
    output logic [5:0]            disp_hi,
    output logic [5:0]            disp_lo,
    output logic [1:0]            mode_o,
    output logic [1:0]            field_o,
    output logic [AW-1:0]         alm_sel,
    output logic [NUM_ALARMS-1:0] alm_en,
    output logic                  ring,
    output logic [AW-1:0]         ring_idx,
    output logic                  sec_tick,
    output logic [5:0]            lap_min,
    output logic [5:0]            lap_sec,
    output logic                  lap_valid
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int RW = $clog2(RING_SECS + 1);

    typedef enum logic [1:0] {NORMAL, SET_TIME, SET_ALARM, STOPWATCH} mode_t;
    typedef enum logic [1:0] {F_IDX, F_HOUR, F_MIN, F_EN} field_t;

    function automatic logic [4:0] inc24(input logic [4:0] v);
        return (v == 5'd23) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] inc60(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    logic [PW-1:0] presc, presc_nx;
    mode_t         mode, mode_nx;
    field_t        field, field_nx;
    logic [4:0]    hour, hour_nx;
    logic [5:0]    minute, min_nx, sec, sec_nx;
    logic [4:0]    alm_hr [NUM_ALARMS];
    logic [5:0]    alm_mn [NUM_ALARMS];
    logic [RW-1:0] ring_cnt;
    logic          sw_run;
    logic [5:0]    sw_mm, sw_ss;
    logic          hit;
    logic [AW-1:0] hit_idx;

    logic edit, ticking, roll, enter_set;
    logic tog_t, tog_a, tog_s, cfm_s;

    assign presc_nx  = (presc == PW'(TICKS_PER_SEC - 1)) ? '0 : presc + 1'b1;
    assign edit      = !mode_p;
    assign ticking   = sec_tick && (mode != SET_TIME);
    assign roll      = ticking && (sec == 6'd59);
    assign enter_set = mode_p && (mode == NORMAL);
    assign tog_t     = edit && toggle_p && (mode == SET_TIME);
    assign tog_a     = edit && toggle_p && (mode == SET_ALARM);
    assign tog_s     = edit && toggle_p && (mode == STOPWATCH);
    assign cfm_s     = edit && confirm_p && (mode == STOPWATCH);
    assign mode_o    = mode;
    assign field_o   = field;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode  <= NORMAL;
            field <= F_IDX;
        end else begin
            mode  <= mode_nx;
            field <= field_nx;
        end
    end

    always_comb begin
        mode_nx  = mode;
        field_nx = field;
        if (mode_p) begin
            mode_nx  = mode_t'(mode + 2'd1);
            field_nx = (mode == NORMAL) ? F_HOUR : F_IDX;
        end else if (confirm_p) begin
            case (mode)
                SET_TIME:  field_nx = (field == F_HOUR) ? F_MIN : F_HOUR;
                SET_ALARM: field_nx = field_t'(field + 2'd1);
                default:   ;
            endcase
        end
    end

    always_comb begin
        hour_nx = hour;
        min_nx  = minute;
        sec_nx  = sec;
        if (ticking) begin
            sec_nx = inc60(sec);
            if (sec == 6'd59) begin
                min_nx = inc60(minute);
                if (minute == 6'd59) hour_nx = inc24(hour);
            end
        end
        if (enter_set) sec_nx = '0;
        if (tog_t && field == F_HOUR) hour_nx = inc24(hour);
        if (tog_t && field == F_MIN) min_nx = inc60(minute);
    end

    // Lowest enabled slot matching the post-rollover hour:min wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (roll && alm_en[i] && alm_hr[i] == hour_nx && alm_mn[i] == min_nx) begin
                hit     = 1'b1;
                hit_idx = AW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            sec_tick <= 1'b0;
            hour     <= '0;
            minute   <= '0;
            sec      <= '0;
        end else begin
            presc    <= presc_nx;
            sec_tick <= (presc_nx == PW'(TICKS_PER_SEC - 1));
            hour     <= hour_nx;
            minute   <= min_nx;
            sec      <= sec_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alm_sel <= '0;
            alm_en  <= '0;
            for (int i = 0; i < NUM_ALARMS; i++) begin
                alm_hr[i] <= '0;
                alm_mn[i] <= '0;
            end
        end else if (tog_a) begin
            case (field)
                F_IDX:   alm_sel <= (alm_sel == AW'(NUM_ALARMS - 1)) ? '0 : alm_sel + 1'b1;
                F_HOUR:  alm_hr[alm_sel] <= inc24(alm_hr[alm_sel]);
                F_MIN:   alm_mn[alm_sel] <= inc60(alm_mn[alm_sel]);
                default: alm_en[alm_sel] <= ~alm_en[alm_sel];
            endcase
        end
    end

    // A silence request outranks a match landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring     <= 1'b0;
            ring_idx <= '0;
            ring_cnt <= '0;
        end else if (stop_ring_p) begin
            ring <= 1'b0;
        end else if (hit) begin
            ring     <= 1'b1;
            ring_idx <= hit_idx;
            ring_cnt <= RW'(RING_SECS);
        end else if (ring && sec_tick) begin
            ring_cnt <= ring_cnt - 1'b1;
            if (ring_cnt == RW'(1)) ring <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_run    <= 1'b0;
            sw_mm     <= '0;
            sw_ss     <= '0;
            lap_min   <= '0;
            lap_sec   <= '0;
            lap_valid <= 1'b0;
        end else begin
            lap_valid <= 1'b0;
            if (tog_s) sw_run <= !sw_run;
            if (cfm_s && !sw_run) begin
                sw_mm   <= '0;
                sw_ss   <= '0;
                lap_min <= '0;
                lap_sec <= '0;
            end else begin
                if (cfm_s) begin
                    lap_min   <= sw_mm;
                    lap_sec   <= sw_ss;
                    lap_valid <= 1'b1;
                end
                if (sw_run && sec_tick) begin
                    sw_ss <= inc60(sw_ss);
                    if (sw_ss == 6'd59) sw_mm <= inc60(sw_mm);
                end
            end
        end
    end

    always_comb begin
        disp_hi = {1'b0, hour};
        disp_lo = minute;
        case (mode)
            SET_ALARM: begin
                disp_hi = {1'b0, alm_hr[alm_sel]};
                disp_lo = alm_mn[alm_sel];
            end
            STOPWATCH: begin
                disp_hi = sw_mm;
                disp_lo = sw_ss;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_watch_core_multi_alarm.sv
// Bench for watch_core_multi_alarm: directed stimulus, outputs compared
// every cycle against a seconds-of-day model plus literal spot checks.
module tb_watch_core_multi_alarm;
    localparam int T  = 4;
    localparam int N  = 4;
    localparam int R  = 3;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mode_p = 1'b0;
    logic toggle_p = 1'b0;
    logic confirm_p = 1'b0;
    logic stop_ring_p = 1'b0;
    logic [5:0] disp_hi, disp_lo, lap_min, lap_sec;
    logic [1:0] mode_o, field_o;
    logic [AW-1:0] alm_sel, ring_idx;
    logic [N-1:0] alm_en;
    logic ring, sec_tick, lap_valid;

    int n_chk = 0;
    int n_fail = 0;

    watch_core_multi_alarm #(
        .TICKS_PER_SEC(T),
        .NUM_ALARMS(N),
        .RING_SECS(R),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mode_p(mode_p),
        .toggle_p(toggle_p),
        .confirm_p(confirm_p),
        .stop_ring_p(stop_ring_p),
        .disp_hi(disp_hi),
        .disp_lo(disp_lo),
        .mode_o(mode_o),
        .field_o(field_o),
        .alm_sel(alm_sel),
        .alm_en(alm_en),
        .ring(ring),
        .ring_idx(ring_idx),
        .sec_tick(sec_tick),
        .lap_min(lap_min),
        .lap_sec(lap_sec),
        .lap_valid(lap_valid)
    );

    always #5 clk = ~clk;

    // Model: time of day and stopwatch as plain second counts,
    // alarms as minute-of-day, ringing as seconds remaining.
    int m_ph, m_tod, m_mode, m_field, m_sel, m_sw;
    int m_lapm, m_laps, m_left, m_ridx;
    int m_am [N];
    bit [N-1:0] m_en;
    bit m_run, m_lapv;

    task automatic model_reset();
        m_ph = 0; m_tod = 0; m_mode = 0; m_field = 0; m_sel = 0;
        m_sw = 0; m_lapm = 0; m_laps = 0; m_left = 0; m_ridx = 0;
        m_en = '0; m_run = 0; m_lapv = 0;
        for (int i = 0; i < N; i++) m_am[i] = 0;
    endtask

    task automatic model_step();
        bit tick, match, orun;
        int midx, h, m, osw;
        tick = (m_ph == T - 1);
        m_ph = (m_ph + 1) % T;
        match = 0;
        midx = 0;
        if (tick && m_mode != 1) begin
            m_tod = (m_tod + 1) % 86400;
            if (m_tod % 60 == 0)
                for (int i = N - 1; i >= 0; i--)
                    if (m_en[i] && m_am[i] == m_tod / 60) begin
                        match = 1;
                        midx = i;
                    end
        end
        if (stop_ring_p) m_left = 0;
        else if (match) begin
            m_left = R;
            m_ridx = midx;
        end else if (tick && m_left > 0) m_left--;
        osw = m_sw;
        orun = m_run;
        m_lapv = 0;
        if (orun && tick) m_sw = (m_sw + 1) % 3600;
        if (mode_p) begin
            if (m_mode == 0) m_tod -= m_tod % 60;
            m_mode = (m_mode + 1) % 4;
            m_field = (m_mode == 1) ? 1 : 0;
        end else begin
            case (m_mode)
                1: begin
                    h = m_tod / 3600;
                    m = (m_tod / 60) % 60;
                    if (toggle_p && m_field == 1)
                        m_tod = ((h + 1) % 24) * 3600 + m * 60 + m_tod % 60;
                    if (toggle_p && m_field == 2)
                        m_tod = h * 3600 + ((m + 1) % 60) * 60 + m_tod % 60;
                    if (confirm_p) m_field = (m_field == 1) ? 2 : 1;
                end
                2: begin
                    if (toggle_p) begin
                        case (m_field)
                            0: m_sel = (m_sel + 1) % N;
                            1: m_am[m_sel] = ((m_am[m_sel] / 60 + 1) % 24) * 60 + m_am[m_sel] % 60;
                            2: m_am[m_sel] = (m_am[m_sel] / 60) * 60 + (m_am[m_sel] % 60 + 1) % 60;
                            default: m_en[m_sel] = !m_en[m_sel];
                        endcase
                    end
                    if (confirm_p) m_field = (m_field + 1) % 4;
                end
                3: begin
                    if (confirm_p && orun) begin
                        m_lapm = osw / 60;
                        m_laps = osw % 60;
                        m_lapv = 1;
                    end
                    if (confirm_p && !orun) begin
                        m_sw = 0;
                        m_lapm = 0;
                        m_laps = 0;
                    end
                    if (toggle_p) m_run = !orun;
                end
                default: ;
            endcase
        end
    endtask

    function automatic int e_hi();
        if (m_mode == 2) return m_am[m_sel] / 60;
        if (m_mode == 3) return m_sw / 60;
        return m_tod / 3600;
    endfunction

    function automatic int e_lo();
        if (m_mode == 2) return m_am[m_sel] % 60;
        if (m_mode == 3) return m_sw % 60;
        return (m_tod / 60) % 60;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("disp_hi", disp_hi, e_hi());
            chk("disp_lo", disp_lo, e_lo());
            chk("mode_o", mode_o, m_mode);
            chk("field_o", field_o, m_field);
            chk("alm_sel", alm_sel, m_sel);
            chk("alm_en", alm_en, m_en);
            chk("ring", ring, m_left != 0);
            chk("ring_idx", ring_idx, m_ridx);
            chk("sec_tick", sec_tick, m_ph == T - 1);
            chk("lap_min", lap_min, m_lapm);
            chk("lap_sec", lap_sec, m_laps);
            chk("lap_valid", lap_valid, m_lapv);
        end
    end

    task automatic step(input logic m, input logic t, input logic c, input logic s);
        mode_p = m;
        toggle_p = t;
        confirm_p = c;
        stop_ring_p = s;
        @(negedge clk);
        mode_p = 1'b0;
        toggle_p = 1'b0;
        confirm_p = 1'b0;
        stop_ring_p = 1'b0;
    endtask

    task automatic mp();
        step(1, 0, 0, 0);
    endtask

    task automatic cfm();
        step(0, 0, 1, 0);
    endtask

    task automatic tog(input int n);
        repeat (n) step(0, 1, 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_tick();
        int k = 0;
        while (sec_tick !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("tick_seen", sec_tick, 1);
    endtask

    initial begin
        int k, n, pre;
        #2 rst = 1'b0;
        idle(2);
        chk("rst_hi", disp_hi, 0);
        chk("rst_lo", disp_lo, 0);
        chk("rst_mode", mode_o, 0);
        chk("rst_en", alm_en, 0);
        rst = 1'b1;

        wait_tick();
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (sec_tick !== 1'b1 && k < 10);
        chk("tick_period", k, 4);

        mp(); tog(23); cfm(); tog(59);
        chk("set_2359_hi", disp_hi, 23);
        chk("set_2359_lo", disp_lo, 59);
        mp(); mp(); mp();
        chk("back_normal", mode_o, 0);
        k = 0;
        while (disp_hi != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("wrap_hi", disp_hi, 0);
        chk("wrap_lo", disp_lo, 0);

        mp(); tog(5); cfm(); tog(3);
        chk("st_mode", mode_o, 1);
        chk("st_field", field_o, 2);
        chk("st_hi", disp_hi, 5);
        chk("st_lo", disp_lo, 3);
        idle(80);
        chk("st_frozen_hi", disp_hi, 5);
        chk("st_frozen_lo", disp_lo, 3);
        mp();
        chk("sa_mode", mode_o, 2);
        chk("sa_field", field_o, 0);

        tog(2);
        chk("sel2", alm_sel, 2);
        cfm(); tog(5); cfm(); tog(4); cfm(); tog(1); cfm(); tog(3);
        chk("sel1", alm_sel, 1);
        cfm(); tog(5); cfm(); tog(4); cfm(); tog(1); cfm();
        chk("en_0110", alm_en, 6);
        chk("alm1_hi", disp_hi, 5);
        chk("alm1_lo", disp_lo, 4);
        mp(); mp();
        k = 0;
        while (ring !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("ring_rise", ring, 1);
        chk("ring_idx_low", ring_idx, 1);
        chk("ring_at_hi", disp_hi, 5);
        chk("ring_at_lo", disp_lo, 4);
        k = 0;
        n = 0;
        while (ring === 1'b1 && k < 50) begin
            if (sec_tick) n++;
            @(negedge clk);
            k++;
        end
        chk("ring_ticks", n, R);
        chk("ring_cleared", ring, 0);

        mp();
        k = 0;
        while (disp_hi != 0 && k < 30) begin
            tog(1);
            k++;
        end
        cfm();
        k = 0;
        while (disp_lo != 0 && k < 70) begin
            tog(1);
            k++;
        end
        chk("mid_hi", disp_hi, 0);
        chk("mid_lo", disp_lo, 0);
        mp(); tog(3);
        chk("sel0", alm_sel, 0);
        cfm(); cfm(); tog(1); cfm(); tog(1); cfm();
        chk("en_0111", alm_en, 7);
        chk("alm0_lo", disp_lo, 1);
        mp(); mp();
        k = 0;
        while (!(m_tod % 60 == 59 && sec_tick === 1'b1) && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk("match_sync", sec_tick, 1);
        step(0, 0, 0, 1);
        chk("stop_wins", ring, 0);
        chk("at_0001_lo", disp_lo, 1);
        chk("en0_kept", alm_en[0], 1);
        idle(8);
        chk("still_quiet", ring, 0);

        mp(); mp(); mp();
        chk("sw_mode", mode_o, 3);
        tog(1);
        k = 0;
        n = 0;
        while (n < 75 && k < 400) begin
            if (sec_tick) n++;
            @(negedge clk);
            k++;
        end
        chk("sw_hi", disp_hi, 1);
        chk("sw_lo", disp_lo, 15);
        cfm();
        chk("lap_v", lap_valid, 1);
        chk("lap_m", lap_min, 1);
        chk("lap_s", lap_sec, 15);
        idle(1);
        chk("lap_v_drop", lap_valid, 0);
        wait_tick();
        pre = m_sw % 60;
        cfm();
        chk("lap_pre_inc", lap_sec, pre);
        tog(1); cfm();
        chk("clr_hi", disp_hi, 0);
        chk("clr_lo", disp_lo, 0);
        chk("clr_lap_m", lap_min, 0);
        chk("clr_lap_s", lap_sec, 0);
        chk("clr_no_v", lap_valid, 0);

        mp(); mp();
        chk("prio_field", field_o, 1);
        step(1, 1, 0, 0);
        chk("prio_mode", mode_o, 2);
        mp(); mp();
        chk("prio_hour", disp_hi, 0);

        mp(); mp(); mp(); tog(1); idle(10);
        mp(); mp(); mp(); cfm();
        #1 rst = 1'b0;
        #1;
        chk("arst_mode", mode_o, 0);
        chk("arst_field", field_o, 0);
        chk("arst_en", alm_en, 0);
        chk("arst_hi", disp_hi, 0);
        chk("arst_sel", alm_sel, 0);
        @(negedge clk);
        rst = 1'b1;
        idle(20);
        mp(); mp(); mp();
        chk("arst_sw_stop_hi", disp_hi, 0);
        chk("arst_sw_stop_lo", disp_lo, 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
